// File: rtl/pipeline_mem_arbiter_pkg.sv
// rtl/pipeline_mem_arbiter_pkg.sv - shared types and state encodings for the memory arbiter
package pipeline_mem_arbiter_pkg;

    // RAM handshake status as reported by the memory model/controller
    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM encoding; kept as plain constants so older code can compare raw bits
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_IGRANT = 2'd1;
    localparam arb_state_t ARB_DGRANT = 2'd2;

endpackage

// File: rtl/pipeline_mem_arbiter_sat_counter.sv
// rtl/pipeline_mem_arbiter_sat_counter.sv - saturating up-counter with clear priority
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             at_limit
);

    assign at_limit = (cnt == WIDTH'(LIMIT));

    // Clear wins over increment; the count holds once it reaches LIMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// rtl/pipeline_mem_arbiter.sv - single-port RAM arbiter between fetch and data access
module pipeline_mem_arbiter
    import pipeline_mem_arbiter_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

    arb_state_t          state;
    arb_state_t          next_state;
    logic [STARVE_W-1:0] starve_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                starve_at_limit;
    logic                wait_at_limit;
    logic                wait_expire;
    logic                wait_inc;
    logic                err_set;
    logic                d_req;

    assign d_req = dREN | dWEN;

    // A granted access times out on the miss that would bring wait_cnt to MAX_WAIT
    assign wait_expire = (wait_cnt == WAIT_W'(MAX_WAIT - 1)) || wait_at_limit;

    // Next-state selection, RAM port steering and completion pulses
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        ihit       = 1'b0;
        dhit       = 1'b0;
        iload      = '0;
        dload      = '0;
        err_set    = 1'b0;
        wait_inc   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (d_req && !(iREN && starve_at_limit)) begin
                    next_state = ARB_DGRANT;
                end else if (iREN) begin
                    next_state = ARB_IGRANT;
                end
            end
            ARB_IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    next_state = ARB_IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    ihit       = 1'b1;
                    iload      = ramload;
                    next_state = ARB_IDLE;
                end else if (ramstate == RAM_ERROR || wait_expire) begin
                    err_set    = 1'b1;
                    next_state = ARB_IDLE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ARB_DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!d_req) begin
                    next_state = ARB_IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dhit       = 1'b1;
                    dload      = ramload;
                    next_state = ARB_IDLE;
                end else if (ramstate == RAM_ERROR || wait_expire) begin
                    err_set    = 1'b1;
                    next_state = ARB_IDLE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // Registered FSM state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sticky error flag, only RST clears it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_err <= 1'b0;
        end else if (err_set) begin
            mem_err <= 1'b1;
        end
    end

    arb_sat_counter #(
        .WIDTH (STARVE_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (CLK),
        .rst      (RST),
        .inc      (dhit & iREN),
        .clr      (ihit | ~iREN),
        .cnt      (starve_cnt),
        .at_limit (starve_at_limit)
    );

    arb_sat_counter #(
        .WIDTH (WAIT_W),
        .LIMIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk      (CLK),
        .rst      (RST),
        .inc      (wait_inc),
        .clr      (~wait_inc),
        .cnt      (wait_cnt),
        .at_limit (wait_at_limit)
    );

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// tb/tb_pipeline_mem_arbiter.sv - scoreboard bench for pipeline_mem_arbiter
module tb_pipeline_mem_arbiter;
    import pipeline_mem_arbiter_pkg::*;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = RAM_FREE;
    logic        mem_err;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    pipeline_mem_arbiter #(.WORD_W(32), .STARVE_LIMIT(4), .MAX_WAIT(255)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic i_r, input logic [31:0] i_a, input logic d_r, input logic d_w,
                         input logic [31:0] d_a, input logic [31:0] d_s, input logic [1:0] rs,
                         input logic [31:0] rl);
        @(negedge CLK);
        iREN = i_r; iaddr = i_a; dREN = d_r; dWEN = d_w; daddr = d_a; dstore = d_s;
        ramstate = rs; ramload = rl;
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, RAM_FREE, 0);
    endtask

    task automatic push_exp(input bit is_d, input logic [31:0] d);
        exp_t e;
        e.is_d = is_d;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Hit monitor: pops the scoreboard on every hit pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (ihit && dhit) begin
                checks++;
                failures++;
                $display("FAIL hit_exclusive: ihit=%0b dhit=%0b both high", ihit, dhit);
            end else if (ihit || dhit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_hit: ihit=%0b dhit=%0b, none expected", ihit, dhit);
                end else begin
                    e = exp_q.pop_front();
                    if (dhit !== e.is_d || (e.is_d ? dload : iload) !== e.data) begin
                        failures++;
                        $display("FAIL hit_data: got dhit=%0b load=%h, expected dhit=%0b load=%h",
                                 dhit, e.is_d ? dload : iload, e.is_d, e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        drive(1, 32'h40, 1, 1, 32'h100, 32'h55, RAM_ACCESS, 32'hFFFF);
        checks++;
        if ({ramREN, ramWEN, ihit, dhit, mem_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000", {ramREN, ramWEN, ihit, dhit, mem_err});
        end
        checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'b0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {ramaddr, ramstore, iload, dload});
        end
        idle_cycle();
        RST = 1'b0;
        idle_cycle();
        checks++;
        if (dut.state !== ARB_IDLE || dut.starve_cnt !== 3'd0 || dut.wait_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got state=%0d starve=%0d wait=%0d expected 0 0 0",
                     dut.state, dut.starve_cnt, dut.wait_cnt);
        end
    endtask

    task automatic test_single_fetch();
        drive(1, 32'h40, 0, 0, 0, 0, RAM_FREE, 0);
        checks++;
        if (ramREN !== 1'b0) begin
            failures++;
            $display("FAIL fetch_c0_ren: got %b expected 0", ramREN);
        end
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                push_exp(0, 32'h8C220004);
                drive(1, 32'h40, 0, 0, 0, 0, RAM_ACCESS, 32'h8C220004);
            end else begin
                drive(1, 32'h40, 0, 0, 0, 0, RAM_BUSY, 0);
            end
            checks++;
            if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin
                failures++;
                $display("FAIL fetch_c%0d_port: got ren=%b wen=%b addr=%h expected 1 0 00000040",
                         c, ramREN, ramWEN, ramaddr);
            end
        end
        idle_cycle();
        checks++;
        if (ramREN !== 1'b0 || dut.state !== ARB_IDLE) begin
            failures++;
            $display("FAIL fetch_done: got ren=%b state=%0d expected 0 0", ramREN, dut.state);
        end
    endtask

    task automatic test_data_priority();
        drive(1, 32'h80, 1, 0, 32'h200, 0, RAM_FREE, 0);
        push_exp(1, 32'h11112222);
        drive(1, 32'h80, 1, 0, 32'h200, 0, RAM_ACCESS, 32'h11112222);
        checks++;
        if (ramaddr !== 32'h200 || ramREN !== 1'b1) begin
            failures++;
            $display("FAIL prio_dgrant: got addr=%h ren=%b expected 00000200 1", ramaddr, ramREN);
        end
        drive(1, 32'h80, 0, 0, 32'h200, 0, RAM_FREE, 0);
        checks++;
        if (ramREN !== 1'b0) begin
            failures++;
            $display("FAIL prio_bubble: got ren=%b expected 0", ramREN);
        end
        push_exp(0, 32'h33334444);
        drive(1, 32'h80, 0, 0, 0, 0, RAM_ACCESS, 32'h33334444);
        checks++;
        if (ramaddr !== 32'h80 || ramREN !== 1'b1) begin
            failures++;
            $display("FAIL prio_igrant: got addr=%h ren=%b expected 00000080 1", ramaddr, ramREN);
        end
        idle_cycle();
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h44, 0, 1, 32'h300, 32'hA0 + k, RAM_FREE, 0);
            push_exp(1, 32'h5000 + k);
            drive(1, 32'h44, 0, 1, 32'h300, 32'hA0 + k, RAM_ACCESS, 32'h5000 + k);
            checks++;
            if (ramWEN !== 1'b1 || ramaddr !== 32'h300) begin
                failures++;
                $display("FAIL starve_dgrant%0d: got wen=%b addr=%h expected 1 00000300", k, ramWEN, ramaddr);
            end
        end
        drive(1, 32'h44, 0, 1, 32'h300, 32'hB0, RAM_FREE, 0);
        checks++;
        if (dut.starve_cnt !== 3'd4) begin
            failures++;
            $display("FAIL starve_cnt_sat: got %0d expected 4", dut.starve_cnt);
        end
        push_exp(0, 32'h6000);
        drive(1, 32'h44, 0, 1, 32'h300, 32'hB0, RAM_ACCESS, 32'h6000);
        checks++;
        if (ramaddr !== 32'h44 || ramREN !== 1'b1 || ramWEN !== 1'b0) begin
            failures++;
            $display("FAIL starve_igrant: got addr=%h ren=%b wen=%b expected 00000044 1 0",
                     ramaddr, ramREN, ramWEN);
        end
        idle_cycle();
        checks++;
        if (dut.starve_cnt !== 3'd0) begin
            failures++;
            $display("FAIL starve_cnt_clr: got %0d expected 0", dut.starve_cnt);
        end
    endtask

    task automatic test_write();
        drive(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, RAM_FREE, 0);
        drive(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, RAM_BUSY, 0);
        checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEADBEEF || ramaddr !== 32'h100) begin
            failures++;
            $display("FAIL write_port: got wen=%b ren=%b store=%h addr=%h expected 1 0 deadbeef 00000100",
                     ramWEN, ramREN, ramstore, ramaddr);
        end
        push_exp(1, 32'h0);
        drive(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, RAM_ACCESS, 32'h0);
        idle_cycle();
    endtask

    task automatic test_abort();
        drive(0, 0, 1, 0, 32'h500, 0, RAM_FREE, 0);
        drive(0, 0, 1, 0, 32'h500, 0, RAM_BUSY, 0);
        checks++;
        if (ramREN !== 1'b1) begin
            failures++;
            $display("FAIL abort_grant: got ren=%b expected 1", ramREN);
        end
        drive(0, 0, 0, 0, 32'h500, 0, RAM_ACCESS, 32'h77);
        checks++;
        if (ramREN !== 1'b0 || dhit !== 1'b0) begin
            failures++;
            $display("FAIL abort_drop: got ren=%b dhit=%b expected 0 0", ramREN, dhit);
        end
        idle_cycle();
        checks++;
        if (dut.state !== ARB_IDLE || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got state=%0d err=%b expected 0 0", dut.state, mem_err);
        end
    endtask

    task automatic test_error();
        drive(0, 0, 1, 0, 32'h600, 0, RAM_FREE, 0);
        drive(0, 0, 1, 0, 32'h600, 0, RAM_ERROR, 0);
        checks++;
        if (mem_err !== 1'b0 || ramREN !== 1'b1) begin
            failures++;
            $display("FAIL error_pre: got err=%b ren=%b expected 0 1", mem_err, ramREN);
        end
        drive(0, 0, 1, 0, 32'h600, 0, RAM_FREE, 0);
        checks++;
        if (mem_err !== 1'b1 || dut.state !== ARB_IDLE) begin
            failures++;
            $display("FAIL error_set: got err=%b state=%0d expected 1 0", mem_err, dut.state);
        end
        push_exp(1, 32'h9999);
        drive(0, 0, 1, 0, 32'h600, 0, RAM_ACCESS, 32'h9999);
        idle_cycle();
        idle_cycle();
        checks++;
        if (mem_err !== 1'b1) begin
            failures++;
            $display("FAIL error_sticky: got err=%b expected 1", mem_err);
        end
    endtask

    task automatic test_reset_mid_access();
        drive(1, 32'h70, 0, 0, 0, 0, RAM_FREE, 0);
        drive(1, 32'h70, 0, 0, 0, 0, RAM_BUSY, 0);
        drive(1, 32'h70, 0, 0, 0, 0, RAM_BUSY, 0);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h70 || dut.wait_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rst_mid_pre: got ren=%b addr=%h wait=%0d expected 1 00000070 1",
                     ramREN, ramaddr, dut.wait_cnt);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (ramREN !== 1'b0 || ramaddr !== 32'h0 || mem_err !== 1'b0 || dut.state !== ARB_IDLE ||
            dut.wait_cnt !== 8'd0 || dut.starve_cnt !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid: got ren=%b addr=%h err=%b state=%0d wait=%0d starve=%0d expected all 0",
                     ramREN, ramaddr, mem_err, dut.state, dut.wait_cnt, dut.starve_cnt);
        end
        idle_cycle();
        RST = 1'b0;
        idle_cycle();
    endtask

    task automatic test_timeout();
        int  busy_cycles = 0;
        bit  seen = 0;
        drive(0, 0, 1, 0, 32'h700, 0, RAM_BUSY, 0);
        for (int c = 0; c < 400 && !seen; c++) begin
            drive(0, 0, 1, 0, 32'h700, 0, RAM_BUSY, 0);
            if (mem_err === 1'b1) seen = 1;
            else if (ramREN === 1'b1) busy_cycles++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL timeout_seen: mem_err never rose within 400 cycles, expected 1");
        end
        checks++;
        if (busy_cycles != 255) begin
            failures++;
            $display("FAIL timeout_len: got %0d granted BUSY cycles expected 255", busy_cycles);
        end
        for (int c = 0; c < 3; c++) idle_cycle();
        checks++;
        if (mem_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got err=%b expected 1", mem_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_priority();
        test_starvation();
        test_write();
        test_abort();
        test_error();
        test_reset_mid_access();
        test_timeout();
        idle_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending hits expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_arbiter.md
Name: pipeline_mem_arbiter

Overview:
- Producer of the ihit/dhit inputs consumed by the hazard unit; sits between the pipelined datapath's instruction/data request ports and the single-ported RAM.
- Arbitrates one RAM port between instruction fetch and data access, with data priority and bounded instruction starvation.
- Returns load data with single-cycle hit pulses, and flags RAM errors and timeouts.

Parameters:
- WORD_W, 32, data/address width in bits.
- STARVE_LIMIT, 4, consecutive data grants allowed while iREN is pending before instruction is forced.
- MAX_WAIT, 255, cycles a granted access may wait for ACCESS before timeout.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  WORD_W  instruction address.
- ihit  out  1  instruction access complete; single-cycle pulse.
- iload  out  WORD_W  instruction word; valid when ihit=1.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  write data.
- dhit  out  1  data access complete; single-cycle pulse.
- dload  out  WORD_W  read data; valid when dhit=1.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.
- mem_err  out  1  sticky error flag; set on ERROR or timeout, cleared only by RST.

Behaviour:
- Reset: state=IDLE, starve_cnt=0, wait_cnt=0, mem_err=0. All outputs are 0 while RST is asserted.
- FSM states: IDLE, IGRANT, DGRANT, held in a registered state.
- IDLE:
  - RAM outputs are 0.
  - dREN|dWEN -> DGRANT, unless iREN=1 and starve_cnt==STARVE_LIMIT, in which case -> IGRANT.
  - Otherwise iREN -> IGRANT.
  - Otherwise stay in IDLE.
- DGRANT, combinational outputs:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN & ~dWEN (write wins if both are set).
- IGRANT, combinational outputs: ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
- Completion (granted state and ramstate==ACCESS):
  - The matching hit pulses the same cycle, and iload/dload = ramload that cycle.
  - Next state is IDLE, so back-to-back accesses carry a one-cycle IDLE bubble.
- Starvation counter:
  - starve_cnt increments on each dhit while iREN=1, saturating at STARVE_LIMIT.
  - It clears on ihit, and on any cycle where iREN=0.
- Wait counter:
  - wait_cnt increments each cycle in a granted state without ACCESS, and clears on leaving the granted state.
  - When it reaches MAX_WAIT: mem_err<=1, -> IDLE, no hit.
- ramstate==ERROR in a granted state: mem_err<=1, -> IDLE, no hit. The requester retries naturally because its request stays high.
- Request withdrawn while granted (DGRANT with dREN=dWEN=0, or IGRANT with iREN=0): RAM enables drop that cycle, -> IDLE, no hit.
- ihit and dhit are never both 1 in the same cycle.
- RST asserted mid-access: immediate return to IDLE, enables drop asynchronously.
- Widths: counters are $clog2(MAX_WAIT+1) and $clog2(STARVE_LIMIT+1) bits. No wrap: the wait counter terminates at MAX_WAIT, the starve counter saturates.

Decomposition:
- cpu_types_pkg (existing): ramstate_t, word_t.
- data_path_muxs_pkg: add arb_state_t enum {IDLE, IGRANT, DGRANT}.
- One natural sub-module: arb_sat_counter (parameterised width/limit, inc/clr, at_limit output), instantiated twice for starve_cnt and wait_cnt.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40; RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C220004 -> ihit pulses in cycle 3 with iload=0x8C220004; ramREN high cycles 1-3.
- Data priority: iREN=dREN=1 together -> DGRANT first with ramaddr=daddr; dhit, then IDLE bubble, then IGRANT and ihit.
- Starvation: iREN held and dWEN asserted continuously with 1-cycle ACCESS -> after 4 dhits the next grant is IGRANT; ihit occurs, starve_cnt returns to 0.
- Write: dWEN=dREN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dhit on ACCESS.
- Error/timeout:
  - ramstate=ERROR during DGRANT -> no dhit, mem_err=1, state IDLE.
  - Separately, BUSY held 255 cycles -> mem_err=1, no hit.
  - mem_err stays 1 until RST.
- Abort and reset: dREN dropped mid-DGRANT -> ramREN drops the same cycle, no dhit; RST pulsed mid-IGRANT -> all outputs 0 immediately, state IDLE, counters 0.
